sprite_blitter: RTL

//  Copies one 4-bit palette-indexed sprite (SPR_W x SPR_H, row-major) from the sprite ROM into the frame buffer.

---
 rtl/sprite_pkg.sv | 24 ++
 rtl/sprite_addr_gen.sv | 71 +++++++
 rtl/sprite_blitter.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/sprite_pkg.sv
// Shared sizes, palette constants and types for the sprite blitter.
package sprite_pkg;
  localparam int SPR_W_DEF     = 126;
  localparam int SPR_H_DEF     = 60;
  localparam int SCR_W_DEF     = 640;
  localparam int SCR_H_DEF     = 480;
  localparam int ADDR_W_DEF    = 13;
  localparam int FB_ADDR_W_DEF = 19;
  localparam logic [3:0] TRANSPARENT_DEF = 4'h0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } blit_state_t;

  typedef logic [3:0] pal_idx_t;

  // A 12-bit two's-complement coordinate is on screen when it is non-negative and below limit.
  function automatic logic in_range(input logic [11:0] coord, input int limit);
    return (coord[11] == 1'b0) && (coord < 12'(limit));
  endfunction
endpackage

// File: rtl/sprite_addr_gen.sv
// Sprite traversal counters: row/col position, incremental row base, mirrored ROM address.
module sprite_addr_gen
  import sprite_pkg::*;
#(
  parameter int SPR_W  = SPR_W_DEF,
  parameter int SPR_H  = SPR_H_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int COL_W  = $clog2(SPR_W),
  parameter int ROW_W  = $clog2(SPR_H)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              flip_in,
  input  logic              advance,
  output logic [ADDR_W-1:0] spr_addr,
  output logic [COL_W-1:0]  col,
  output logic [ROW_W-1:0]  row,
  output logic              last
);
  logic [COL_W-1:0]  col_r, nxt_col_s;
  logic [ROW_W-1:0]  row_r, nxt_row_s;
  logic [ADDR_W-1:0] base_r, nxt_base_s, nxt_addr_s, spr_addr_r;
  logic              flip_r, row_end_s;

  // Next pixel position; the row base steps by SPR_W so no multiplier is needed.
  always_comb begin
    row_end_s = (col_r == COL_W'(SPR_W - 1));
    if (row_end_s) begin
      nxt_col_s  = {COL_W{1'b0}};
      nxt_row_s  = row_r + ROW_W'(1);
      nxt_base_s = base_r + ADDR_W'(SPR_W);
    end else begin
      nxt_col_s  = col_r + COL_W'(1);
      nxt_row_s  = row_r;
      nxt_base_s = base_r;
    end
    if (flip_r) begin
      nxt_addr_s = nxt_base_s + (ADDR_W'(SPR_W - 1) - ADDR_W'(nxt_col_s));
    end else begin
      nxt_addr_s = nxt_base_s + ADDR_W'(nxt_col_s);
    end
  end

  // Traversal registers; load restarts at pixel (0,0) and captures the flip mode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_r      <= {COL_W{1'b0}};
      row_r      <= {ROW_W{1'b0}};
      base_r     <= {ADDR_W{1'b0}};
      spr_addr_r <= {ADDR_W{1'b0}};
      flip_r     <= 1'b0;
    end else if (load) begin
      col_r      <= {COL_W{1'b0}};
      row_r      <= {ROW_W{1'b0}};
      base_r     <= {ADDR_W{1'b0}};
      flip_r     <= flip_in;
      spr_addr_r <= flip_in ? ADDR_W'(SPR_W - 1) : {ADDR_W{1'b0}};
    end else if (advance) begin
      col_r      <= nxt_col_s;
      row_r      <= nxt_row_s;
      base_r     <= nxt_base_s;
      spr_addr_r <= nxt_addr_s;
    end
  end

  assign spr_addr = spr_addr_r;
  assign col      = col_r;
  assign row      = row_r;
  assign last     = row_end_s && (row_r == ROW_W'(SPR_H - 1));
endmodule

// File: rtl/sprite_blitter.sv
// Copies a palette-indexed sprite from ROM into the frame buffer with clipping,
// transparency and optional horizontal mirroring.
module sprite_blitter
  import sprite_pkg::*;
#(
  parameter int         SPR_W       = SPR_W_DEF,
  parameter int         SPR_H       = SPR_H_DEF,
  parameter int         SCR_W       = SCR_W_DEF,
  parameter int         SCR_H       = SCR_H_DEF,
  parameter logic [3:0] TRANSPARENT = TRANSPARENT_DEF,
  parameter int         ADDR_W      = ADDR_W_DEF,
  parameter int         FB_ADDR_W   = FB_ADDR_W_DEF
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  input  logic                 start,
  input  logic signed [10:0]   pos_x,
  input  logic signed [10:0]   pos_y,
  input  logic                 flip_h,
  output logic [ADDR_W-1:0]    spr_addr,
  input  logic [3:0]           spr_data,
  output logic [FB_ADDR_W-1:0] fb_addr,
  output logic [3:0]           fb_data,
  output logic                 fb_we,
  input  logic                 fb_ready,
  output logic                 busy,
  output logic                 done
);
  localparam int COL_W = $clog2(SPR_W);
  localparam int ROW_W = $clog2(SPR_H);

  blit_state_t          state_r, state_s;
  logic [10:0]          pos_x_r, pos_y_r;
  logic                 fetch_on_r, busy_r, done_r;
  logic                 rd_valid_r, hold_valid_r;
  logic [COL_W-1:0]     rd_col_r, col_s;
  logic [ROW_W-1:0]     rd_row_r, row_s;
  pal_idx_t             hold_data_r, pix_s, fb_data_r;
  logic [FB_ADDR_W-1:0] fb_addr_r, fb_addr_s;
  logic                 fb_we_r, we_s;
  logic                 stall_s, accept_s, adv_s, last_s;
  logic [11:0]          sx_s, sy_s;

  assign stall_s  = fb_we_r && !fb_ready;
  assign accept_s = (state_r == IDLE) && start;
  assign adv_s    = fetch_on_r && !stall_s;

  sprite_addr_gen #(
    .SPR_W (SPR_W),
    .SPR_H (SPR_H),
    .ADDR_W(ADDR_W),
    .COL_W (COL_W),
    .ROW_W (ROW_W)
  ) u_addr_gen (
    .clk     (Clk),
    .rst_n   (Reset_n),
    .load    (accept_s),
    .flip_in (flip_h),
    .advance (adv_s && !last_s),
    .spr_addr(spr_addr),
    .col     (col_s),
    .row     (row_s),
    .last    (last_s)
  );

  // State register.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state_r <= IDLE;
    else          state_r <= state_s;
  end

  // Next state; DONE covers the final write until the frame buffer accepts it.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_s = FETCH;
        else       state_s = IDLE;
      end
      FETCH: state_s = RUN;
      RUN: begin
        if (!stall_s && rd_valid_r && !fetch_on_r) state_s = DONE;
        else                                       state_s = RUN;
      end
      DONE: begin
        if (!stall_s) state_s = IDLE;
        else          state_s = DONE;
      end
      default: state_s = IDLE;
    endcase
  end

  // Write-stage pixel: clip, transparency test and fb address (y*640 as two shifts).
  always_comb begin
    if (hold_valid_r) pix_s = hold_data_r;
    else              pix_s = spr_data;
    sx_s      = {pos_x_r[10], pos_x_r} + 12'(rd_col_r);
    sy_s      = {pos_y_r[10], pos_y_r} + 12'(rd_row_r);
    fb_addr_s = FB_ADDR_W'({sy_s, 9'b0}) + FB_ADDR_W'({sy_s, 7'b0}) + FB_ADDR_W'(sx_s);
    we_s      = rd_valid_r && (pix_s != TRANSPARENT) &&
                in_range(sx_s, SCR_W) && in_range(sy_s, SCR_H);
  end

  // Launch bookkeeping: latched position, fetch enable, busy and the done pulse.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pos_x_r    <= 11'd0;
      pos_y_r    <= 11'd0;
      fetch_on_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (accept_s) begin
        pos_x_r    <= pos_x;
        pos_y_r    <= pos_y;
        fetch_on_r <= 1'b1;
        busy_r     <= 1'b1;
      end else if (adv_s && last_s) begin
        fetch_on_r <= 1'b0;
      end
      if ((state_r == DONE) && !stall_s) begin
        busy_r <= 1'b0;
        done_r <= 1'b1;
      end
    end
  end

  // Read/write pipeline. While stalled the ROM already returns the next word, so the
  // pending pixel's data is parked in hold_data_r on the first stalled edge.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rd_valid_r   <= 1'b0;
      rd_col_r     <= {COL_W{1'b0}};
      rd_row_r     <= {ROW_W{1'b0}};
      hold_valid_r <= 1'b0;
      hold_data_r  <= 4'h0;
      fb_we_r      <= 1'b0;
      fb_addr_r    <= {FB_ADDR_W{1'b0}};
      fb_data_r    <= 4'h0;
    end else if (!stall_s) begin
      rd_valid_r   <= fetch_on_r;
      rd_col_r     <= col_s;
      rd_row_r     <= row_s;
      hold_valid_r <= 1'b0;
      fb_we_r      <= we_s;
      if (rd_valid_r) begin
        fb_addr_r <= fb_addr_s;
        fb_data_r <= pix_s;
      end
    end else if (!hold_valid_r) begin
      hold_valid_r <= 1'b1;
      hold_data_r  <= spr_data;
    end
  end

  assign fb_addr = fb_addr_r;
  assign fb_data = fb_data_r;
  assign fb_we   = fb_we_r;
  assign busy    = busy_r;
  assign done    = done_r;
endmodule
